// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Widths derive from NREQ/MAXBURST through clog2_min1 so single-entry cases keep a 1-bit field.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int NREQ_DFLT     = 4;
  localparam int MAXBURST_DFLT = 4;
  localparam int DSIZE_DFLT    = 8;

  localparam int IDXW = clog2_min1(NREQ_DFLT);
  localparam int CNTW = clog2_min1(MAXBURST_DFLT);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side bundle; master is the arbiter, slave is requesters plus FIFO.
// The FIFO sees only winc/wdata/wfull; everything else is requester-facing.
interface fifo_wr_arbiter_if #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       grant;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;

  modport master (
    input  req, req_data, wfull,
    output ack, grant, winc, wdata, busy
  );

  modport slave (
    output req, req_data, wfull,
    input  ack, grant, winc, wdata, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req scanning last+1, last+2, ... modulo NREQ.
// Zero latency; pick_vld low when no request is pending.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick_oh,
  output logic [IW-1:0]   pick_idx,
  output logic            pick_vld
);

  logic [IW-1:0] cand;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    // i == NREQ wraps back to last itself, so the previous owner is considered last
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld       = 1'b1;
        pick_idx       = cand;
        pick_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port; grant one cycle after req, then up to MAXBURST words at 1/cycle.
// wfull stalls the burst indefinitely; a dropped owner req ends it; one idle cycle separates bursts.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic              wclk,
  input  logic              wrst,
  fifo_wr_arbiter_if.master bus
);

  localparam int IW = clog2_min1(NREQ);
  localparam int CW = clog2_min1(MAXBURST);

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] grant_q, grant_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic [NREQ-1:0]  pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic             owner_req;
  logic             wr;
  logic [DSIZE-1:0] wdata_mux;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req      (bus.req),
    .last     (last),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // grant_q is zero outside BURST, so the mux naturally yields zero data when idle
  always_comb begin
    owner_req = |(bus.req & grant_q);
    wr        = (state == BURST) && owner_req && !bus.wfull;
    wdata_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        wdata_mux = bus.req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign bus.winc  = wr;
  assign bus.ack   = wr ? grant_q : '0;
  assign bus.wdata = (state == BURST) ? wdata_mux : '0;
  assign bus.grant = grant_q;
  assign bus.busy  = (state == BURST);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = BURST;
          grant_nxt = pick_oh;
          owner_nxt = pick_idx;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        // the final word of a full-length burst is still written in the ending cycle
        if (!owner_req || (wr && (cnt == CW'(MAXBURST - 1)))) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = owner;
          cnt_nxt   = '0;
        end else if (wr) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state   <= IDLE;
      grant_q <= '0;
      owner   <= '0;
      last    <= IW'(NREQ - 1);
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO between `NREQ` producers in the write-clock domain. Grants one requester at a time for a burst of up to `MAXBURST` words, drives `winc`/`wdata` into the FIFO, and respects `wfull` back-pressure. Sits directly in front of the FIFO write side; the read side is untouched.

## Interface

- `DSIZE`, 8, data word width (matches FIFO `DSIZE`)
- `NREQ`, 4, number of requesters (2..16)
- `MAXBURST`, 4, max words accepted per grant (1..256)

- `wclk`  in  1  write-domain clock, all logic on rising edge
- `wrst`  in  1  asynchronous, active-high reset
- `req`  in  NREQ  per-requester "word valid"
- `req_data`  in  NREQ*DSIZE  requester i word at bits [i*DSIZE +: DSIZE]
- `wfull`  in  1  FIFO full flag
- `ack`  out  NREQ  one-hot; word of requester i written this cycle
- `grant`  out  NREQ  registered one-hot owner, 0 when idle
- `winc`  out  1  FIFO write enable
- `wdata`  out  DSIZE  FIFO write data
- `busy`  out  1  high in BURST state

## Operation

- States: IDLE, BURST. Registers: `state`, `grant`, `last` (index of previous owner), `cnt` (0..MAXBURST-1).
- IDLE: if `req != 0`, pick first asserted index scanning `last+1, last+2, ...` modulo NREQ; `grant <=` one-hot of it, `cnt <= 0`, go BURST. Otherwise stay.
- BURST, owner g: `winc = req[g] & ~wfull`; `wdata = req_data[g]`; `ack[g] = winc`, other ack bits 0.
- Accepted word: `cnt <= cnt+1`. If `cnt == MAXBURST-1`, end the burst.
- `req[g] == 0` at a clock edge ends the burst; no word is written that cycle.
- `wfull` high: no write, `cnt` holds, burst held indefinitely (no timeout).
- End of burst: `state <= IDLE`, `grant <= 0`, `last <= g`.
- Outside BURST: `winc = 0`, `ack = 0`, `wdata = 0`.
- Requester rule: hold `req_data` stable while `req` is high until `ack`; the next word may be presented in the cycle after `ack`.

## Timing

- Reset (async assert, sync release): state IDLE, `grant = 0`, `busy = 0`, `cnt = 0`, `last = NREQ-1` (requester 0 has first priority), `winc = 0`, `ack = 0`, `wdata = 0`.
- `req` high at edge k in IDLE → `grant`/`busy` high after edge k → first write in cycle k+1 (latency 1).
- Throughput in a burst: 1 word/cycle while not full.
- One mandatory IDLE cycle between consecutive bursts, including same-requester re-grant.
- `winc`, `wdata`, `ack` are combinational from `grant`, `req`, `wfull`, `req_data`; `grant` and `busy` are registered.
- Reset mid-burst drops `winc` immediately; any partially accepted burst is not replayed.

## Structure

- Package `fifo_arb_pkg`: state enum (IDLE, BURST) and width constants `IDXW = $clog2(NREQ)`, `CNTW = $clog2(MAXBURST)` (min 1).
- Sub-module `rr_pick`: combinational round-robin picker, inputs `req`, `last`, outputs one-hot and index.

## Test plan

- Reset, then `req=4'b0001`, continuous data 0x10..0x13 → `grant=0001` one cycle later, four `winc` pulses writing 0x10..0x13, then IDLE for 1 cycle, then re-grant to 0001.
- `req=4'b1111`, all held → grants in order 0001, 0010, 0100, 1000, 0001, each 4 words, 1 IDLE cycle between bursts.
- Requester 2 only, `wfull` high for 3 cycles mid-burst after 2 words → `winc=0` for those 3 cycles, `cnt` holds at 2, remaining 2 words written after `wfull` falls.
- Requester 1 drops `req` after 2 words → burst ends, `grant=0`, next grant goes to the next higher index with `req` high.
- `wrst` pulsed while in BURST with `winc=1` → outputs zero asynchronously; after release, first grant goes to the lowest active index.
- End-to-end with the FIFO at DSIZE=8, ASIZE=3: 3 requesters each push 8 tagged words, slow read clock → read stream contains all 24 words with per-requester order preserved and no writes while `wfull` is high.
